alu_exec_stage: RTL and testbench
=================================

Name: alu_exec_stage

Overview:
Execute-stage ALU for the 5-stage MIPS pipeline. It consumes the 3-bit ALU operation code produced by the ALU control decoder, together with two operands and a destination tag. It computes the result and delivers it to the EX/MEM boundary through a registered valid/ready interface. A 2-entry skid buffer lets MEM stalls propagate back without a combinational ready path.

Parameters:
WIDTH, 32, operand/result width in bits (>=4)
TAGW, 5, destination register tag width

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  ID/EX presents an operation
in_ready  out  1  stage can accept this cycle (registered)
alu_oper  in  3  000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT; 011/100/101 illegal
src_a  in  WIDTH  operand A
src_b  in  WIDTH  operand B
rd_in  in  TAGW  destination tag, passed through
flush  in  1  synchronous kill of all held entries
out_valid  out  1  result available to EX/MEM
out_ready  in  1  EX/MEM accepts
result  out  WIDTH  ALU result
zero  out  1  result == 0
overflow  out  1  signed overflow (ADD/SUB only)
illegal  out  1  entry carried an illegal alu_oper
rd_out  out  TAGW  tag of the presented result

Behaviour:
- Reset (async, rst_n=0): both entries invalid; out_valid=0; in_ready=1; result, rd_out, zero, overflow, illegal all 0. Deassertion is synchronised by the system; the block samples normally on the next rising edge.
- Accept: in_valid & in_ready at a rising edge. Result/flags are computed combinationally from the inputs and captured at that edge. Latency is 1 cycle: out_valid rises the cycle after accept when the stage was empty.
- Arithmetic:
  - AND/OR are bitwise.
  - ADD = src_a+src_b mod 2^WIDTH; overflow = (a[msb]==b[msb]) & (r[msb]!=a[msb]).
  - SUB = src_a-src_b mod 2^WIDTH; overflow = (a[msb]!=b[msb]) & (r[msb]!=a[msb]).
  - SLT = 1 if src_a < src_b as signed, else 0, zero-extended. The compare must be correct even when a-b overflows. overflow = 0.
  - AND/OR/SLT: overflow = 0.
  - Illegal codes: result = 0, zero = 1, overflow = 0, illegal = 1.
- zero is derived from the stored result, not recomputed from the inputs.
- States (count of held entries):
  - EMPTY: out_valid=0, in_ready=1.
  - ONE (main valid): out_valid=1, in_ready=1.
  - TWO (main + skid valid): out_valid=1, in_ready=0.
- Transitions, with A = accept and D = out_valid & out_ready:
  - EMPTY: A -> ONE.
  - ONE: A & D -> ONE (main replaced by the new entry). A & !D -> TWO (new entry goes to skid). !A & D -> EMPTY. Otherwise hold.
  - TWO: D -> ONE (skid moves into main). Otherwise hold. No accept is possible since in_ready=0.
- Ordering is strictly FIFO; the skid entry is never presented before the main entry.
- in_ready is a flop output: in_ready = !(next state == TWO).
- Outputs stay stable while out_valid=1 & out_ready=0.
- flush has priority over everything:
  - At a flushing edge both entries are invalidated and any simultaneous input is dropped.
  - Next cycle: out_valid=0, in_ready=1.
  - Data registers may keep stale values; flags and result are don't-care while out_valid=0.
- Reset mid-operation: all entries are discarded immediately (async), and outputs go to their reset values.
- No accept occurs without in_valid. in_valid while in_ready=0 is ignored; upstream holds its data.

Test Plan:
- Reset, then ADD a=7, b=5, out_ready=1 -> one cycle later out_valid=1, result=12, zero=0, overflow=0.
- SUB a=0x7FFFFFFF, b=0xFFFFFFFF -> result=0x80000000, overflow=1. ADD a=0x80000000, b=0x80000000 -> result=0, zero=1, overflow=1.
- SLT a=0x80000000, b=1 -> result=1. SLT a=5, b=5 -> result=0, zero=1. AND 0xF0F0,0xFF00 -> 0xF000. OR -> 0xFFF0.
- Backpressure: hold out_ready=0 and issue ops tags 1, 2, 3 back-to-back -> tags 1 and 2 accepted, in_ready=0 from the cycle after tag 2 is accepted, tag 3 held. Release out_ready -> outputs tag 1, 2, 3 in order with no loss or duplication.
- Illegal alu_oper=100 -> illegal=1, result=0, zero=1. Flush asserted while in TWO with in_valid=1 -> next cycle out_valid=0, in_ready=1, and no later output carries the flushed tags.
- Assert rst_n=0 asynchronously between edges while in TWO -> out_valid and result drop to 0 immediately and in_ready=1.

Source files
------------

// File: rtl/alu_exec_stage_if.sv
// Interface bundle for the execute-stage ALU.
//   Upstream side (ID/EX):  in_valid, in_ready, alu_oper, src_a, src_b, rd_in, flush
//   Downstream side (EX/MEM): out_valid, out_ready, result, zero, overflow, illegal, rd_out
// Modports:
//   slave  - the ALU stage itself
//   master - whoever drives the operations and consumes the results
interface alu_exec_stage_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned TAGW  = 5
);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       alu_oper;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic [TAGW-1:0]  rd_in;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             overflow;
  logic             illegal;
  logic [TAGW-1:0]  rd_out;

  modport slave (
    input  in_valid, alu_oper, src_a, src_b, rd_in, flush, out_ready,
    output in_ready, out_valid, result, zero, overflow, illegal, rd_out
  );

  modport master (
    output in_valid, alu_oper, src_a, src_b, rd_in, flush, out_ready,
    input  in_ready, out_valid, result, zero, overflow, illegal, rd_out
  );
endinterface

// File: rtl/alu_exec_stage.sv
// Execute-stage ALU for a 5-stage MIPS pipeline.
// Computes AND/OR/ADD/SUB/SLT on the accepted operands and holds the result in a
// 2-entry (main + skid) buffer so downstream stalls never create a combinational
// ready path back to ID/EX.
// Ports:
//   clk    - rising-edge clock
//   rst_n  - asynchronous active-low reset
//   bus    - alu_exec_stage_if.slave: upstream valid/ready + operands + flush,
//            downstream valid/ready + result, zero, overflow, illegal, rd_out
module alu_exec_stage #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned TAGW  = 5
) (
  input logic               clk,
  input logic               rst_n,
  alu_exec_stage_if.slave   bus
);

  localparam logic [2:0] OpAnd = 3'b000;
  localparam logic [2:0] OpOr  = 3'b001;
  localparam logic [2:0] OpAdd = 3'b010;
  localparam logic [2:0] OpSub = 3'b110;
  localparam logic [2:0] OpSlt = 3'b111;

  typedef struct packed {
    logic [WIDTH-1:0] result;
    logic [TAGW-1:0]  rd;
    logic             ovf;
    logic             ill;
  } entry_t;

  typedef enum logic [1:0] {StEmpty, StOne, StTwo} state_e;

  state_e state_q;
  entry_t main_q, skid_q;
  logic   out_valid_q, in_ready_q;
  entry_t new_entry;

  logic [WIDTH-1:0] sum, diff;
  logic             slt_lt;
  logic             accept, deq;

  // ALU datapath, evaluated on the current inputs and captured at accept.
  always_comb begin
    sum       = bus.src_a + bus.src_b;
    diff      = bus.src_a - bus.src_b;
    // Native signed compare stays correct when a-b would overflow.
    slt_lt    = $signed(bus.src_a) < $signed(bus.src_b);
    new_entry = '0;
    new_entry.rd = bus.rd_in;
    case (bus.alu_oper)
      OpAnd: new_entry.result = bus.src_a & bus.src_b;
      OpOr:  new_entry.result = bus.src_a | bus.src_b;
      OpAdd: begin
        new_entry.result = sum;
        new_entry.ovf    = (bus.src_a[WIDTH-1] == bus.src_b[WIDTH-1]) &
                           (sum[WIDTH-1] != bus.src_a[WIDTH-1]);
      end
      OpSub: begin
        new_entry.result = diff;
        new_entry.ovf    = (bus.src_a[WIDTH-1] != bus.src_b[WIDTH-1]) &
                           (diff[WIDTH-1] != bus.src_a[WIDTH-1]);
      end
      OpSlt: new_entry.result = {{(WIDTH-1){1'b0}}, slt_lt};
      default: new_entry.ill = 1'b1;
    endcase
  end

  assign accept = bus.in_valid & in_ready_q;
  assign deq    = out_valid_q & bus.out_ready;

  // Occupancy FSM; out_valid/in_ready are registered alongside the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StEmpty;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      main_q      <= '0;
      skid_q      <= '0;
    end else if (bus.flush) begin
      // Data registers are left stale; only validity is cleared.
      state_q     <= StEmpty;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      case (state_q)
        StEmpty: begin
          if (accept) begin
            main_q      <= new_entry;
            state_q     <= StOne;
            out_valid_q <= 1'b1;
            in_ready_q  <= 1'b1;
          end
        end
        StOne: begin
          if (accept && deq) begin
            main_q <= new_entry;
          end else if (accept) begin
            skid_q     <= new_entry;
            state_q    <= StTwo;
            in_ready_q <= 1'b0;
          end else if (deq) begin
            state_q     <= StEmpty;
            out_valid_q <= 1'b0;
          end
        end
        StTwo: begin
          if (deq) begin
            main_q     <= skid_q;
            state_q    <= StOne;
            in_ready_q <= 1'b1;
          end
        end
        default: begin
          state_q     <= StEmpty;
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.result    = main_q.result;
  assign bus.rd_out    = main_q.rd;
  assign bus.overflow  = main_q.ovf;
  assign bus.illegal   = main_q.ill;
  // Gated by out_valid so the reset value is 0 even though result resets to 0.
  assign bus.zero      = out_valid_q & (main_q.result == '0);

endmodule

// File: tb/tb_alu_exec_stage.sv
module tb_alu_exec_stage;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned TAGW  = 5;

  typedef struct {
    logic [31:0] res;
    logic        zero;
    logic        ovf;
    logic        ill;
    logic [4:0]  rd;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_pass   = 0;
  exp_t mq[$];

  alu_exec_stage_if #(.WIDTH(WIDTH), .TAGW(TAGW)) bus ();

  alu_exec_stage #(.WIDTH(WIDTH), .TAGW(TAGW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  // Reference model: signed arithmetic on wide integers, overflow by range test.
  function automatic exp_t ref_alu(input logic [2:0] op, input logic [31:0] a,
                                   input logic [31:0] b, input logic [4:0] rd);
    exp_t   e;
    longint sa, sb, s;
    sa = $signed(a);
    sb = $signed(b);
    e.res = 0; e.ovf = 0; e.ill = 0; e.rd = rd;
    case (op)
      3'd0: e.res = a & b;
      3'd1: e.res = a | b;
      3'd2: begin
        s = sa + sb;
        e.res = s[31:0];
        e.ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      3'd6: begin
        s = sa - sb;
        e.res = s[31:0];
        e.ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      3'd7: e.res = (sa < sb) ? 32'd1 : 32'd0;
      default: e.ill = 1;
    endcase
    e.zero = (e.res == 0);
    return e;
  endfunction

  task automatic check_outputs();
    check("out_valid", bus.out_valid, mq.size() > 0);
    check("in_ready", bus.in_ready, mq.size() < 2);
    if (mq.size() > 0) begin
      check("result", bus.result, mq[0].res);
      check("zero", bus.zero, mq[0].zero);
      check("overflow", bus.overflow, mq[0].ovf);
      check("illegal", bus.illegal, mq[0].ill);
      check("rd_out", bus.rd_out, mq[0].rd);
    end
  endtask

  // Drive one cycle at the negedge, update the model for the coming posedge,
  // then compare at the following negedge.
  task automatic step(input logic v, input logic [2:0] op, input logic [31:0] a,
                      input logic [31:0] b, input logic [4:0] rd,
                      input logic ordy, input logic fl);
    bit acc, dq;
    bus.in_valid  = v;
    bus.alu_oper  = op;
    bus.src_a     = a;
    bus.src_b     = b;
    bus.rd_in     = rd;
    bus.out_ready = ordy;
    bus.flush     = fl;
    acc = v && (mq.size() < 2);
    dq  = (mq.size() > 0) && ordy;
    if (fl) mq.delete();
    else begin
      if (dq) void'(mq.pop_front());
      if (acc) mq.push_back(ref_alu(op, a, b, rd));
    end
    @(negedge clk);
    check_outputs();
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'h7FFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    bus.in_valid = 0; bus.alu_oper = 0; bus.src_a = 0; bus.src_b = 0;
    bus.rd_in = 0; bus.flush = 0; bus.out_ready = 0;
    rst_n = 0;
    repeat (2) @(negedge clk);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_result", bus.result, 0);
    check("rst_rd_out", bus.rd_out, 0);
    check("rst_zero", bus.zero, 0);
    check("rst_overflow", bus.overflow, 0);
    check("rst_illegal", bus.illegal, 0);
    rst_n = 1;
    @(negedge clk);

    // Arithmetic corner cases.
    step(1, 3'b010, 32'd7, 32'd5, 5'd1, 1, 0);
    check("add_res", bus.result, 12); check("add_zero", bus.zero, 0);
    check("add_ovf", bus.overflow, 0);
    step(1, 3'b110, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 5'd2, 1, 0);
    check("sub_res", bus.result, 32'h8000_0000); check("sub_ovf", bus.overflow, 1);
    step(1, 3'b010, 32'h8000_0000, 32'h8000_0000, 5'd3, 1, 0);
    check("addo_res", bus.result, 0); check("addo_zero", bus.zero, 1);
    check("addo_ovf", bus.overflow, 1);
    step(1, 3'b111, 32'h8000_0000, 32'd1, 5'd4, 1, 0);
    check("slt_neg", bus.result, 1);
    step(1, 3'b111, 32'd5, 32'd5, 5'd5, 1, 0);
    check("slt_eq", bus.result, 0); check("slt_eq_zero", bus.zero, 1);
    step(1, 3'b000, 32'hF0F0, 32'hFF00, 5'd6, 1, 0);
    check("and_res", bus.result, 32'hF000);
    step(1, 3'b001, 32'hF0F0, 32'hFF00, 5'd7, 1, 0);
    check("or_res", bus.result, 32'hFFF0);
    step(1, 3'b100, 32'd9, 32'd3, 5'd8, 1, 0);
    check("ill_flag", bus.illegal, 1); check("ill_res", bus.result, 0);
    check("ill_zero", bus.zero, 1);
    step(0, 3'b000, 0, 0, 0, 1, 0);

    // Backpressure: tags 1,2 fill the buffer, tag 3 waits.
    step(1, 3'b010, 32'd1, 32'd1, 5'd1, 0, 0);
    step(1, 3'b010, 32'd2, 32'd2, 5'd2, 0, 0);
    check("bp_in_ready", bus.in_ready, 0);
    step(1, 3'b010, 32'd3, 32'd3, 5'd3, 0, 0);
    step(1, 3'b010, 32'd3, 32'd3, 5'd3, 0, 0);
    check("bp_hold_rd", bus.rd_out, 1);
    step(1, 3'b010, 32'd3, 32'd3, 5'd3, 1, 0);
    check("bp_rd2", bus.rd_out, 2);
    step(1, 3'b010, 32'd3, 32'd3, 5'd3, 1, 0);
    check("bp_rd3", bus.rd_out, 3);
    step(0, 3'b000, 0, 0, 0, 1, 0);
    check("bp_drained", bus.out_valid, 0);

    // Flush while full with a simultaneous input.
    step(1, 3'b001, 32'd1, 32'd0, 5'd10, 0, 0);
    step(1, 3'b001, 32'd2, 32'd0, 5'd11, 0, 0);
    step(1, 3'b001, 32'd3, 32'd0, 5'd12, 0, 1);
    check("fl_out_valid", bus.out_valid, 0); check("fl_in_ready", bus.in_ready, 1);
    step(1, 3'b001, 32'd4, 32'd0, 5'd13, 1, 0);
    check("fl_next_rd", bus.rd_out, 13);
    step(0, 3'b000, 0, 0, 0, 1, 0);

    // Asynchronous reset while full.
    step(1, 3'b010, 32'd20, 32'd1, 5'd20, 0, 0);
    step(1, 3'b010, 32'd21, 32'd1, 5'd21, 0, 0);
    #2 rst_n = 0;
    #1;
    check("arst_out_valid", bus.out_valid, 0);
    check("arst_result", bus.result, 0);
    check("arst_in_ready", bus.in_ready, 1);
    mq.delete();
    bus.in_valid = 0;
    @(negedge clk);
    rst_n = 1;
    check_outputs();

    // Randomized traffic against the queue model.
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)), pick_operand(),
           pick_operand(), 5'($urandom), $urandom_range(0, 2) != 0,
           $urandom_range(0, 31) == 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
